// File: rtl/maze_game_pkg.sv
// Shared types and constants for the maze game session logic.
package maze_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_PLAY,
        ST_LEVEL_DONE,
        ST_WON,
        ST_LOST
    } state_e;

    localparam int TIME_W = 12;

    function automatic logic [TIME_W-1:0] budget(input int mins, input int secs);
        return TIME_W'(mins * 60 + secs);
    endfunction

endpackage

// File: rtl/maze_sec_countdown.sv
// Seconds countdown: a CLK_F-cycle prescaler feeding a non-underflowing
// seconds register with synchronous budget load.
module maze_sec_countdown
    import maze_game_pkg::*;
#(
    parameter int                CLK_F  = 50000000,
    parameter logic [TIME_W-1:0] BUDGET = TIME_W'(60)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic              run_i,
    output logic [TIME_W-1:0] time_left_o,
    output logic              zero_o
);

    localparam int PRE_W = (CLK_F > 1) ? $clog2(CLK_F) : 1;

    logic [PRE_W-1:0]  pre_q;
    logic [TIME_W-1:0] time_q;
    logic              tick;

    assign tick        = run_i && (pre_q == PRE_W'(CLK_F - 1));
    assign time_left_o = time_q;
    assign zero_o      = (time_q == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q  <= '0;
            time_q <= BUDGET;
        end else begin
            // Clearing on entry makes every level's first tick land CLK_F cycles in.
            if (clr_i) begin
                pre_q <= '0;
            end else if (run_i) begin
                pre_q <= tick ? '0 : pre_q + 1'b1;
            end

            if (load_i) begin
                time_q <= BUDGET;
            end else if (tick && time_q != '0) begin
                time_q <= time_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/maze_session_ctrl.sv
// Multi-level maze session FSM: generation handshake, play, level scoring,
// win/lose; owns the countdown via maze_sec_countdown.
module maze_session_ctrl
    import maze_game_pkg::*;
#(
    parameter int NUM_LEVELS = 8,
    parameter int MINS       = 1,
    parameter int SECS       = 0,
    parameter int CLK_F      = 50000000,
    parameter int TIME_MODE  = 0,
    parameter int SCORE_W    = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              gen_end,
    input  logic                              player_at_end,
    output logic                              gen_start,
    output logic                              hold_player,
    output logic                              stop_player,
    output logic [$clog2(NUM_LEVELS+1)-1:0]   level,
    output logic [TIME_W-1:0]                 time_left,
    output logic [SCORE_W-1:0]                score,
    output logic                              game_won,
    output logic                              game_lost
);

    localparam int                LVL_W    = $clog2(NUM_LEVELS + 1);
    localparam logic [TIME_W-1:0] BUDGET   = budget(MINS, SECS);
    localparam logic [LVL_W-1:0]  LAST_LVL = LVL_W'(NUM_LEVELS - 1);

    state_e             state_q;
    logic               gen_start_q;
    logic               hold_q;
    logic               stop_q;
    logic               won_q;
    logic               lost_q;
    logic               armed_q;
    logic               pae_q;
    logic [LVL_W-1:0]   level_q;
    logic [SCORE_W-1:0] score_q;

    logic [TIME_W-1:0]  time_left_s;
    logic               time_zero;
    logic               can_start;
    logic               exit_rise;
    logic               enter_play;
    logic               in_play;
    logic               load_budget;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [TIME_W-1:0]  b);
        logic [32:0] sum;
        sum = 33'(a) + 33'(b);
        if (sum > 33'({SCORE_W{1'b1}})) begin
            return {SCORE_W{1'b1}};
        end
        return sum[SCORE_W-1:0];
    endfunction

    assign can_start   = (state_q == ST_IDLE) || (state_q == ST_WON) || (state_q == ST_LOST);
    assign exit_rise   = player_at_end && !pae_q;
    assign enter_play  = (state_q == ST_GEN) && armed_q && gen_end;
    assign in_play     = (state_q == ST_PLAY);
    assign load_budget = (can_start && start) ||
                         ((state_q == ST_LEVEL_DONE) && (TIME_MODE == 1) && (level_q != LAST_LVL));

    maze_sec_countdown #(
        .CLK_F  (CLK_F),
        .BUDGET (BUDGET)
    ) u_countdown (
        .clock       (clock),
        .reset       (reset),
        .load_i      (load_budget),
        .clr_i       (enter_play),
        .run_i       (in_play),
        .time_left_o (time_left_s),
        .zero_o      (time_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gen_start_q <= 1'b0;
            hold_q      <= 1'b1;
            stop_q      <= 1'b1;
            won_q       <= 1'b0;
            lost_q      <= 1'b0;
            armed_q     <= 1'b0;
            pae_q       <= 1'b1;
            level_q     <= '0;
            score_q     <= '0;
        end else begin
            gen_start_q <= 1'b0;
            pae_q       <= player_at_end;
            case (state_q)
                ST_IDLE, ST_WON, ST_LOST: begin
                    if (start) begin
                        state_q     <= ST_GEN;
                        gen_start_q <= 1'b1;
                        hold_q      <= 1'b1;
                        stop_q      <= 1'b1;
                        won_q       <= 1'b0;
                        lost_q      <= 1'b0;
                        armed_q     <= 1'b0;
                        level_q     <= '0;
                        score_q     <= '0;
                    end
                end
                ST_GEN: begin
                    // A done flag left high by the previous maze must drop before it counts.
                    if (!gen_end) begin
                        armed_q <= 1'b1;
                    end
                    if (armed_q && gen_end) begin
                        state_q <= ST_PLAY;
                        hold_q  <= 1'b0;
                        stop_q  <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (exit_rise) begin
                        state_q <= ST_LEVEL_DONE;
                        stop_q  <= 1'b1;
                    end else if (time_zero) begin
                        state_q <= ST_LOST;
                        stop_q  <= 1'b1;
                        lost_q  <= 1'b1;
                    end
                end
                ST_LEVEL_DONE: begin
                    score_q <= sat_add(score_q, time_left_s);
                    level_q <= level_q + 1'b1;
                    if (level_q == LAST_LVL) begin
                        state_q <= ST_WON;
                        won_q   <= 1'b1;
                    end else begin
                        state_q     <= ST_GEN;
                        gen_start_q <= 1'b1;
                        hold_q      <= 1'b1;
                        armed_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    hold_q  <= 1'b1;
                    stop_q  <= 1'b1;
                end
            endcase
        end
    end

    assign gen_start   = gen_start_q;
    assign hold_player = hold_q;
    assign stop_player = stop_q;
    assign level       = level_q;
    assign time_left   = time_left_s;
    assign score       = score_q;
    assign game_won    = won_q;
    assign game_lost   = lost_q;

endmodule
